// File: rtl/wb_master_standard_pkg.sv
// Shared types and defaults for the Wishbone classic master: FSM state encoding
// and the default bus widths.
package wb_pkg;

  localparam int WB_AW_DEFAULT = 16;
  localparam int WB_DW_DEFAULT = 16;
  localparam int WB_CNT_W      = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wb_master_standard_if.sv
// Command/response handshake plus Wishbone classic master bus for wb_master_standard.
// The master modport is the block's view; the slave modport is the environment's view.
interface wb_master_standard_if #(
  parameter int AW = wb_pkg::WB_AW_DEFAULT,
  parameter int DW = wb_pkg::WB_DW_DEFAULT
);

  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_we;
  logic [AW-1:0] cmd_adr;
  logic [DW-1:0] cmd_dat;

  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_dat;
  logic          rsp_err;

  logic          wb_cyc;
  logic          wb_stb;
  logic          wb_we;
  logic [AW-1:0] wb_adr;
  logic [DW-1:0] wb_dat_o;
  logic [DW-1:0] wb_dat_i;
  logic          wb_ack;
  logic          wb_stall;

  modport master (
    input  cmd_valid, cmd_we, cmd_adr, cmd_dat, rsp_ready, wb_dat_i, wb_ack, wb_stall,
    output cmd_ready, rsp_valid, rsp_dat, rsp_err, wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_o
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_adr, cmd_dat, rsp_ready, wb_dat_i, wb_ack, wb_stall,
    input  cmd_ready, rsp_valid, rsp_dat, rsp_err, wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_o
  );

endinterface

// File: rtl/wb_master_standard.sv
// Single-outstanding Wishbone classic master: command -> one bus cycle -> response, with ack timeout.
// Latency 2 cycles min (ack in first BUS cycle); response held until rsp_ready, no new command meanwhile.
module wb_master_standard
  import wb_pkg::*;
#(
  parameter int AW      = WB_AW_DEFAULT,
  parameter int DW      = WB_DW_DEFAULT,
  parameter int TIMEOUT = 255
) (
  input logic                  clk,
  input logic                  rst_n,
  wb_master_standard_if.master bus
);

  localparam logic [WB_CNT_W-1:0] TIMEOUT_C = WB_CNT_W'(TIMEOUT);

  wb_state_e           state_q, state_d;
  logic [WB_CNT_W-1:0] cnt_q, cnt_d;
  logic                wb_we_q, wb_we_d;
  logic [AW-1:0]       wb_adr_q, wb_adr_d;
  logic [DW-1:0]       wb_dat_q, wb_dat_d;
  logic [DW-1:0]       rsp_dat_q, rsp_dat_d;
  logic                rsp_err_q, rsp_err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Ack takes priority over an expiring counter in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.cmd_valid) state_d = BUS;
      BUS:     if (bus.wb_ack || (cnt_q == TIMEOUT_C)) state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_ready = (state_q == IDLE);
    bus.wb_cyc    = (state_q == BUS);
    bus.wb_stb    = (state_q == BUS);
    bus.rsp_valid = (state_q == RESP);
    bus.wb_we     = wb_we_q;
    bus.wb_adr    = wb_adr_q;
    bus.wb_dat_o  = wb_dat_q;
    bus.rsp_dat   = rsp_dat_q;
    bus.rsp_err   = rsp_err_q;
  end

  always_comb begin
    cnt_d     = cnt_q;
    wb_we_d   = wb_we_q;
    wb_adr_d  = wb_adr_q;
    wb_dat_d  = wb_dat_q;
    rsp_dat_d = rsp_dat_q;
    rsp_err_d = rsp_err_q;
    if ((state_q == IDLE) && bus.cmd_valid) begin
      cnt_d    = '0;
      wb_we_d  = bus.cmd_we;
      wb_adr_d = bus.cmd_adr;
      wb_dat_d = bus.cmd_dat;
    end else if (state_q == BUS) begin
      if (bus.wb_ack) begin
        rsp_dat_d = wb_we_q ? '0 : bus.wb_dat_i;
        rsp_err_d = 1'b0;
      end else if (cnt_q == TIMEOUT_C) begin
        rsp_dat_d = '0;
        rsp_err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      wb_we_q   <= 1'b0;
      wb_adr_q  <= '0;
      wb_dat_q  <= '0;
      rsp_dat_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      wb_we_q   <= wb_we_d;
      wb_adr_q  <= wb_adr_d;
      wb_dat_q  <= wb_dat_d;
      rsp_dat_q <= rsp_dat_d;
      rsp_err_q <= rsp_err_d;
    end
  end

endmodule

// File: doc/wb_master_standard.md
WB_MASTER_STANDARD -- requirements
Module: wb_master_standard

Interface
REQ-001 Parameter AW, default 16: Wishbone address width in bits.
REQ-002 Parameter DW, default 16: Wishbone data width in bits.
REQ-003 Parameter TIMEOUT, default 255: maximum wait for ack, in cycles after the strobe is first asserted; legal range 1..65535.
REQ-004 clk  in  1  single clock; all logic is on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 cmd_valid  in  1  command present.
REQ-007 cmd_ready  out  1  command accepted when cmd_valid is also high.
REQ-008 cmd_we  in  1  1 = write, 0 = read.
REQ-009 cmd_adr  in  AW  target address.
REQ-010 cmd_dat  in  DW  write data.
REQ-011 rsp_valid  out  1  response present.
REQ-012 rsp_ready  in  1  response consumed when rsp_valid is also high.
REQ-013 rsp_dat  out  DW  read data; 0 for writes and for timed-out reads.
REQ-014 rsp_err  out  1  transfer ended by timeout.
REQ-015 wb_cyc, wb_stb, wb_we  out  1 each  Wishbone classic master controls.
REQ-016 wb_adr  out  AW  Wishbone address.
REQ-017 wb_dat_o  out  DW  Wishbone write data.
REQ-018 wb_dat_i  in  DW  Wishbone read data.
REQ-019 wb_ack  in  1  Wishbone acknowledge.
REQ-020 wb_stall  in  1  Wishbone stall; sampled but not acted on (classic cycles).

Function
REQ-021 The FSM SHALL have three states: IDLE, BUS and RESP.
REQ-022 cmd_ready SHALL equal (state == IDLE).
- A handshake moves IDLE to BUS.
- On that edge, cmd_we, cmd_adr and cmd_dat SHALL be registered into wb_we, wb_adr and wb_dat_o.
REQ-023 In BUS, wb_cyc and wb_stb SHALL be 1; in all other states they SHALL be 0.
- wb_we, wb_adr and wb_dat_o SHALL hold stable throughout BUS.
REQ-024 In BUS with wb_ack = 1, the FSM SHALL move to RESP.
- rsp_dat SHALL capture wb_dat_i for a read, or 0 for a write.
- rsp_err SHALL be cleared to 0.
REQ-025 A 16-bit wait counter SHALL clear on IDLE-to-BUS and increment each BUS cycle without ack.
- When the counter equals TIMEOUT with no ack, the FSM SHALL move to RESP with rsp_err = 1 and rsp_dat = 0.
REQ-026 If ack arrives in the same cycle the counter reaches TIMEOUT, ack SHALL win and rsp_err SHALL be 0.
REQ-027 rsp_valid SHALL equal (state == RESP).
- A handshake moves RESP to IDLE.
- rsp_dat and rsp_err SHALL hold stable while rsp_valid = 1 and rsp_ready = 0.
REQ-028 Timing rules:
- One transfer is outstanding at most.
- Minimum command-to-response latency: 2 cycles (ack in the first BUS cycle, rsp_valid on the next cycle).
- Minimum throughput: one transfer per 3 cycles.
REQ-029 wb_ack sampled outside BUS SHALL be ignored.

Reset
REQ-030 On rst_n low, the block SHALL enter IDLE immediately, without waiting for a clock edge.
- State after reset: wb_cyc = wb_stb = wb_we = 0, wb_adr = 0, wb_dat_o = 0, rsp_valid = 0, rsp_dat = 0, rsp_err = 0, counter = 0.
REQ-031 Reset asserted mid-transfer SHALL drop wb_cyc and wb_stb immediately and discard the transfer; no response SHALL be produced.
REQ-032 Reset release SHALL take effect on a rising clk edge.
- cmd_ready SHALL be 1 in the first cycle after release.

Structure
REQ-033 The FSM state enum (IDLE, BUS, RESP) SHALL be defined in shared package wb_pkg.
- The same package SHALL hold the default AW and DW constants.
REQ-034 The block SHALL be a single module with no sub-module.
- The bench SHALL pair it with the existing single-cycle-ack standard slave (64k x 16 RAM).

Verification
REQ-035 Write then read with the standard slave:
- Write adr 0x1234, dat 0xBEEF -> rsp_err 0, rsp_dat 0.
- Read adr 0x1234 -> rsp_dat 0xBEEF, rsp_err 0.
- Each response arrives 2 cycles after the command handshake.
REQ-036 Back-to-back: 8 writes to adr 0..7 (dat = adr * 3) followed by 8 reads, with cmd_valid held high throughout -> reads return 0,3,...,21; wb_cyc pulses exactly once per transfer.
REQ-037 Timeout with TIMEOUT = 4 and the slave acking never -> rsp_err 1 and rsp_dat 0 on the response; wb_cyc is high for exactly 5 cycles (count 0..4).
REQ-038 Ack on the timeout cycle, with TIMEOUT = 4 and ack in the 5th BUS cycle -> rsp_err 0 and rsp_dat = wb_dat_i.
REQ-039 Response backpressure: rsp_ready held low for 10 cycles -> rsp_valid, rsp_dat and rsp_err stay stable; cmd_ready stays 0; no new Wishbone cycle starts.
REQ-040 Reset in the 2nd BUS cycle of a read -> wb_cyc drops in the same cycle; no rsp_valid appears; cmd_ready is 1 after release.
